// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and constants for the router packet source.
//   tx_state_e : transmit FSM states
//   hdr_pack() : builds the router header byte {len, addr}
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_e;

  function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
//   Payload store: DEPTH x DW, one synchronous write port, one combinational read port.
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address (load count)
//   wdata in  write data
//   raddr in  read address (transmit index)
//   rdata out read data, combinational from raddr
module router_tx_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//   Packet source for the 1x3 router input port. Takes a request (addr, len),
//   buffers the whole payload, then sends header, payload and parity with no
//   gaps on the router side, stalling while the router reports busy.
//   Ports:
//     clk, reset                 clock / synchronous active-high reset
//     req_valid/req_ready        request handshake; req_addr (2b), req_len (6b)
//     req_drop                   1-cycle pulse after an illegal request is consumed
//     pl_valid/pl_ready/pl_data  payload byte stream (accepted only in LOAD)
//     busy                       router busy, holds the current byte
//     packet_valid, pkt_data     router-side byte stream
//     tx_done                    high in the cycle the parity byte is transferred
//   Optional build macro ROUTER_TX_PARITY_INJ_EN adds inj_parity_err, sampled at
//   request accept; when set the parity byte is sent inverted.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_drop,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  output logic              packet_valid,
  output logic [DATA_W-1:0] pkt_data,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic              inj_parity_err,
`endif
  output logic              tx_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic [LEN_W-1:0]  idx_q,   idx_d;
  logic [DATA_W-1:0] par_q,   par_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic              drop_q,  drop_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic              inj_q,   inj_d;
`endif

  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  router_tx_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W),
    .DW    (DATA_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (pl_data),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  assign req_drop = drop_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    par_d        = par_q;
    gap_d        = gap_q;
    drop_d       = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    inj_d        = inj_q;
`endif
    buf_we       = 1'b0;
    req_ready    = 1'b0;
    pl_ready     = 1'b0;
    packet_valid = 1'b0;
    pkt_data     = '0;
    tx_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing looks acceptable mid-reset.
        req_ready = !reset;
        if (req_valid) begin
          if (req_addr == ADDR_ILLEGAL || req_len == '0) begin
            drop_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            len_d   = req_len;
            cnt_d   = '0;
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj_d   = inj_parity_err;
`endif
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // Whole payload is buffered first: the router side may not see a gap.
        pl_ready = 1'b1;
        if (pl_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == len_q) state_d = HEADER;
        end
      end
      HEADER: begin
        packet_valid = 1'b1;
        pkt_data     = hdr_pack(len_q, addr_q);
        if (!busy) begin
          par_d   = hdr_pack(len_q, addr_q);
          idx_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        packet_valid = 1'b1;
        pkt_data     = buf_rdata;
        if (!busy) begin
          par_d = par_q ^ buf_rdata;
          idx_d = idx_q + 6'd1;
          if (idx_q == len_q - 6'd1) state_d = PARITY;
        end
      end
      PARITY: begin
`ifdef ROUTER_TX_PARITY_INJ_EN
        pkt_data = inj_q ? ~par_q : par_q;
`else
        pkt_data = par_q;
`endif
        if (!busy) begin
          tx_done = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                 gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      par_q   <= '0;
      gap_q   <= '0;
      drop_q  <= 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj_q   <= inj_d;
`endif
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx
//   Directed bench for router_pkt_tx: reset state, normal packet, busy stalls,
//   illegal requests, max-length packet with throttled payload, mid-packet reset,
//   and (when ROUTER_TX_PARITY_INJ_EN is defined) inverted parity.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_drop;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       packet_valid;
  logic [7:0] pkt_data;
  logic       tx_done;
  logic       inj;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pl [64];

  always #5 clk = ~clk;

  router_pkt_tx #(.GAP_CYCLES(2), .MAX_LEN(63)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_drop       (req_drop),
    .pl_valid       (pl_valid),
    .pl_ready       (pl_ready),
    .pl_data        (pl_data),
    .busy           (busy),
    .packet_valid   (packet_valid),
    .pkt_data       (pkt_data),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .inj_parity_err (inj),
`endif
    .tx_done        (tx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Request, load payload pl[0..l-1], then check the router-side stream.
  // stall_at: payload index held under busy for stall_n cycles (-1 none).
  // abort_at: return as soon as payload index abort_at is on the bus (-1 none).
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l,
                          input logic [7:0] hdr, input logic [7:0] par,
                          input int stall_at, input int stall_n,
                          input bit par_stall, input bit toggle, input int abort_at);
    req_valid = 1'b1; req_addr = a; req_len = l;
    chk("req_ready_idle", req_ready, 1);
    chk("pl_ready_idle", pl_ready, 0);
    step();
    req_valid = 1'b0;
    chk("pl_ready_load", pl_ready, 1);
    chk("req_ready_load", req_ready, 0);
    for (int i = 0; i < int'(l); i++) begin
      if (toggle) begin
        pl_valid = 1'b0; pl_data = 8'hEE;
        step();
        chk("pv_during_load", packet_valid, 0);
      end
      pl_valid = 1'b1; pl_data = pl[i];
      step();
    end
    pl_valid = 1'b0; pl_data = 8'hEE;
    chk("hdr_pv", packet_valid, 1);
    chk("hdr_data", pkt_data, hdr);
    chk("hdr_pl_ready", pl_ready, 0);
    step();
    for (int i = 0; i < int'(l); i++) begin
      if (i == abort_at) return;
      chk("pl_pv", packet_valid, 1);
      chk("pl_data", pkt_data, pl[i]);
      chk("pl_tx_done", tx_done, 0);
      if (i == stall_at) begin
        busy = 1'b1;
        for (int k = 0; k < stall_n; k++) begin
          step();
          chk("stall_data", pkt_data, pl[i]);
          chk("stall_pv", packet_valid, 1);
        end
        busy = 1'b0;
      end
      step();
    end
    chk("par_pv", packet_valid, 0);
    chk("par_data", pkt_data, par);
    if (par_stall) begin
      busy = 1'b1; #1;
      chk("par_stall_tx_done", tx_done, 0);
      step();
      chk("par_stall_data", pkt_data, par);
      busy = 1'b0; #1;
    end
    chk("par_tx_done", tx_done, 1);
    step();
    chk("gap1_req_ready", req_ready, 0);
    chk("gap1_pv", packet_valid, 0);
    chk("gap1_data", pkt_data, 0);
    chk("gap1_tx_done", tx_done, 0);
    step();
    chk("gap2_req_ready", req_ready, 0);
    step();
    chk("idle_req_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; inj = 1'b0;

    // Reset state
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_pv", packet_valid, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_drop", req_drop, 0);
    chk("rst_tx_done", tx_done, 0);
    reset = 1'b0; #1;
    chk("post_rst_req_ready", req_ready, 1);

    // 1: addr=1 len=3 payload 11,22,33 -> header 0D, parity 0D
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 8'h0D, 8'h0D, -1, 0, 1'b0, 1'b0, -1);

    // 2: same packet, 22 held under busy for 3 extra cycles
    send_pkt(2'd1, 6'd3, 8'h0D, 8'h0D, 1, 3, 1'b0, 1'b0, -1);
    // 2b: busy during header-less parity cycle delays tx_done
    send_pkt(2'd1, 6'd3, 8'h0D, 8'h0D, 0, 1, 1'b1, 1'b0, -1);

    // 3: illegal requests addr=3 and len=0; stray pl_valid is ignored
    pl_valid = 1'b1; pl_data = 8'h77;
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    step();
    chk("drop1", req_drop, 1);
    chk("drop1_pl_ready", pl_ready, 0);
    chk("drop1_req_ready", req_ready, 1);
    req_addr = 2'd2; req_len = 6'd0;
    step();
    chk("drop2", req_drop, 1);
    chk("drop2_pv", packet_valid, 0);
    req_valid = 1'b0;
    step();
    chk("drop_end", req_drop, 0);
    chk("drop_end_pv", packet_valid, 0);
    chk("drop_end_pl_ready", pl_ready, 0);
    pl_valid = 1'b0;

    // 4: addr=2 len=63 payload 00..3E, throttled input -> header FE, parity C1
    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    send_pkt(2'd2, 6'd63, 8'hFE, 8'hC1, -1, 0, 1'b0, 1'b1, -1);

    // 5: reset while payload index 10 is on the bus
    send_pkt(2'd1, 6'd20, 8'h51, 8'h00, -1, 0, 1'b0, 1'b0, 10);
    chk("pre_abort_data", pkt_data, 8'h0A);
    reset = 1'b1;
    step();
    chk("abort_pv", packet_valid, 0);
    chk("abort_data", pkt_data, 0);
    chk("abort_req_ready_in_rst", req_ready, 0);
    reset = 1'b0; #1;
    chk("abort_req_ready", req_ready, 1);
    pl[0] = 8'h5A;
    send_pkt(2'd0, 6'd1, 8'h04, 8'h5E, -1, 0, 1'b0, 1'b0, -1);

`ifdef ROUTER_TX_PARITY_INJ_EN
    // 6: inverted parity: 04^AA=AE, sent as 51
    inj = 1'b1;
    pl[0] = 8'hAA;
    send_pkt(2'd0, 6'd1, 8'h04, 8'h51, -1, 0, 1'b0, 1'b0, -1);
    inj = 1'b0;
    // injection is per request: next packet has correct parity AE
    send_pkt(2'd0, 6'd1, 8'h04, 8'hAE, -1, 0, 1'b0, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
